// File: rtl/johnson_pkg.sv
// Shared definitions for the Johnson-code phase tracker and its benches.
// Contents:
//   jpt_state_e     - tracker FSM states
//   jc_is_legal()   - code is 0*1* or 1*0* over the low n bits
//   jc_to_phase()   - legal code -> phase index 0..2n-1
//   jc_next_phase() - phase successor modulo 2n
package johnson_pkg;

    typedef enum logic [1:0] {
        ACQ    = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } jpt_state_e;

    // Functions take a fixed-width code plus the live width n, so one copy
    // serves every parameterisation.
    localparam int JC_MAX_W = 32;

    // A legal Johnson code has at most one 0/1 boundary between adjacent bits.
    function automatic logic jc_is_legal(input logic [JC_MAX_W-1:0] code, input int n);
        int bnd;
        bnd = 0;
        for (int i = 0; i < JC_MAX_W - 1; i++) begin
            if ((i < n - 1) && (code[i] != code[i+1])) bnd++;
        end
        return (bnd <= 1);
    endfunction

    // Filling phase (0*1*, includes all-zero): phase = number of ones.
    // Draining phase (1*0*, bit0 clear, nonzero): phase = 2n - number of ones.
    function automatic int jc_to_phase(input logic [JC_MAX_W-1:0] code, input int n);
        int ones;
        ones = 0;
        for (int i = 0; i < JC_MAX_W; i++) begin
            if ((i < n) && code[i]) ones++;
        end
        if (code[0] || (ones == 0)) return ones;
        return 2 * n - ones;
    endfunction

    function automatic int jc_next_phase(input int phase, input int n);
        return (phase >= 2 * n - 1) ? 0 : phase + 1;
    endfunction

endpackage

// File: rtl/johnson_decode.sv
// Combinational Johnson-code decoder.
// Ports:
//   i_jc    in  N   sampled Johnson code
//   o_legal out 1   code is one of the 2N legal codes
//   o_phase out PW  phase index (meaningful only when o_legal)
module johnson_decode
    import johnson_pkg::*;
#(
    parameter int N = 4,
    localparam int PW = $clog2(2 * N)
) (
    input  logic [N-1:0]  i_jc,
    output logic          o_legal,
    output logic [PW-1:0] o_phase
);

    logic [JC_MAX_W-1:0] w_code;

    assign w_code  = JC_MAX_W'(i_jc);
    assign o_legal = jc_is_legal(w_code, N);
    assign o_phase = PW'(jc_to_phase(w_code, N));

endmodule

// File: rtl/johnson_phase_tracker.sv
// Johnson-code phase tracker: decodes each valid sample, checks it against the
// expected successor, acquires/holds lock and counts revolutions while locked.
// Ports:
//   i_clk, i_reset     clock, synchronous active-high reset
//   i_in_valid         i_jc_in carries a sample this cycle
//   i_jc_in [N]        Johnson code
//   i_err_clr          clears sticky o_err_any
//   o_phase [PW]       phase of last legal sample
//   o_phase_valid      o_phase holds a legal decode
//   o_lock             FSM is LOCKED
//   o_rev_tick         pulse on locked wrap 2N-1 -> 0
//   o_rev_count [CW]   revolutions while locked (wraps)
//   o_err_illegal      pulse: sample was not a Johnson code
//   o_err_seq          pulse: wrong successor while locked
//   o_err_any          sticky error flag
module johnson_phase_tracker
    import johnson_pkg::*;
#(
    parameter int N          = 4,
    parameter int LOCK_CNT   = 3,
    parameter int CW         = 8,
    parameter int ALLOW_HOLD = 0,
    localparam int PW        = $clog2(2 * N)
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_in_valid,
    input  logic [N-1:0]  i_jc_in,
    input  logic          i_err_clr,
    output logic [PW-1:0] o_phase,
    output logic          o_phase_valid,
    output logic          o_lock,
    output logic          o_rev_tick,
    output logic [CW-1:0] o_rev_count,
    output logic          o_err_illegal,
    output logic          o_err_seq,
    output logic          o_err_any
);

    localparam int CNTW = $clog2(LOCK_CNT + 1);

    jpt_state_e     r_state, w_state_nxt;
    logic [PW-1:0]  r_phase, w_phase_nxt;
    logic           r_phase_valid, w_pv_nxt;
    logic [CNTW-1:0] r_cnt, w_cnt_nxt;
    logic [CW-1:0]  r_rev_count, w_rc_nxt;
    logic           r_rev_tick, w_tick_nxt;
    logic           r_err_illegal, w_ill_nxt;
    logic           r_err_seq, w_seq_nxt;
    logic           r_err_any, w_any_nxt;

    logic           w_legal;
    logic [PW-1:0]  w_dec_phase;
    logic [PW-1:0]  w_exp_phase;
    logic           w_match;
    logic           w_hold;
    logic [CNTW-1:0] w_cnt_inc;

    johnson_decode #(.N(N)) u_decode (
        .i_jc    (i_jc_in),
        .o_legal (w_legal),
        .o_phase (w_dec_phase)
    );

    assign w_exp_phase = PW'(jc_next_phase(int'(r_phase), N));
    assign w_match     = w_legal && (w_dec_phase == w_exp_phase);
    // Same code as the last recorded one; only meaningful once a phase is held.
    assign w_hold      = w_legal && r_phase_valid && (w_dec_phase == r_phase);
    assign w_cnt_inc   = r_cnt + CNTW'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_pv_nxt    = r_phase_valid;
        w_cnt_nxt   = r_cnt;
        w_rc_nxt    = r_rev_count;
        w_tick_nxt  = 1'b0;
        w_ill_nxt   = 1'b0;
        w_seq_nxt   = 1'b0;
        if (i_in_valid) begin
            if (!w_legal) begin
                w_ill_nxt = 1'b1;
                if (r_state != ACQ) begin
                    w_state_nxt = ACQ;
                    w_pv_nxt    = 1'b0;
                end
            end else if ((ALLOW_HOLD != 0) && w_hold) begin
                // Stalled counter: keep everything as is.
            end else begin
                // Every legal, non-held sample becomes the recorded phase.
                w_phase_nxt = w_dec_phase;
                w_pv_nxt    = 1'b1;
                case (r_state)
                    ACQ: begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = VERIFY;
                    end
                    VERIFY: begin
                        if (w_match) begin
                            if (w_cnt_inc == CNTW'(LOCK_CNT)) begin
                                w_cnt_nxt   = '0;
                                w_state_nxt = LOCKED;
                            end else begin
                                w_cnt_nxt = w_cnt_inc;
                            end
                        end else begin
                            w_cnt_nxt = '0;
                        end
                    end
                    LOCKED: begin
                        if (w_match) begin
                            if (r_phase == PW'(2 * N - 1)) begin
                                w_tick_nxt = 1'b1;
                                w_rc_nxt   = r_rev_count + CW'(1);
                            end
                        end else begin
                            w_seq_nxt   = 1'b1;
                            w_cnt_nxt   = '0;
                            w_state_nxt = VERIFY;
                        end
                    end
                    default: begin
                        w_state_nxt = ACQ;
                        w_pv_nxt    = 1'b0;
                    end
                endcase
            end
        end
        // A fresh error wins over a coincident clear.
        w_any_nxt = (r_err_any & ~i_err_clr) | w_ill_nxt | w_seq_nxt;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= ACQ;
            r_phase       <= '0;
            r_phase_valid <= 1'b0;
            r_cnt         <= '0;
            r_rev_count   <= '0;
            r_rev_tick    <= 1'b0;
            r_err_illegal <= 1'b0;
            r_err_seq     <= 1'b0;
            r_err_any     <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_phase       <= w_phase_nxt;
            r_phase_valid <= w_pv_nxt;
            r_cnt         <= w_cnt_nxt;
            r_rev_count   <= w_rc_nxt;
            r_rev_tick    <= w_tick_nxt;
            r_err_illegal <= w_ill_nxt;
            r_err_seq     <= w_seq_nxt;
            r_err_any     <= w_any_nxt;
        end
    end

    assign o_phase       = r_phase;
    assign o_phase_valid = r_phase_valid;
    assign o_lock        = (r_state == LOCKED);
    assign o_rev_tick    = r_rev_tick;
    assign o_rev_count   = r_rev_count;
    assign o_err_illegal = r_err_illegal;
    assign o_err_seq     = r_err_seq;
    assign o_err_any     = r_err_any;

endmodule

// File: tb/tb_johnson_phase_tracker.sv
// Scoreboard bench for johnson_phase_tracker. Two instances share stimulus:
// u_dut (ALLOW_HOLD=0, fully checked) and u_hold (ALLOW_HOLD=1, lock/err_seq
// checked). The driver pushes hand-written expectations at each negedge; the
// monitor pops and compares one entry just after each posedge.
module tb_johnson_phase_tracker;

    logic       clk = 1'b0;
    logic       reset, in_valid, err_clr;
    logic [3:0] jc_in;

    logic [2:0] phase, phase_h;
    logic       phase_valid, lock, rev_tick, err_illegal, err_seq, err_any;
    logic       phase_valid_h, lock_h, rev_tick_h, err_illegal_h, err_seq_h, err_any_h;
    logic [7:0] rev_count, rev_count_h;

    always #5 clk = ~clk;

    johnson_phase_tracker #(.N(4), .LOCK_CNT(3), .CW(8), .ALLOW_HOLD(0)) u_dut (
        .i_clk(clk), .i_reset(reset), .i_in_valid(in_valid), .i_jc_in(jc_in),
        .i_err_clr(err_clr), .o_phase(phase), .o_phase_valid(phase_valid),
        .o_lock(lock), .o_rev_tick(rev_tick), .o_rev_count(rev_count),
        .o_err_illegal(err_illegal), .o_err_seq(err_seq), .o_err_any(err_any)
    );

    johnson_phase_tracker #(.N(4), .LOCK_CNT(3), .CW(8), .ALLOW_HOLD(1)) u_hold (
        .i_clk(clk), .i_reset(reset), .i_in_valid(in_valid), .i_jc_in(jc_in),
        .i_err_clr(err_clr), .o_phase(phase_h), .o_phase_valid(phase_valid_h),
        .o_lock(lock_h), .o_rev_tick(rev_tick_h), .o_rev_count(rev_count_h),
        .o_err_illegal(err_illegal_h), .o_err_seq(err_seq_h), .o_err_any(err_any_h)
    );

    typedef struct packed {
        logic [2:0] ph;
        logic       pv, lk, tk;
        logic [7:0] rc;
        logic       ill, sq, any, lkh, sqh;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    logic [7:0] m_rc;
    logic       m_any;
    int   cur_ph;

    localparam logic [3:0] JC [8] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111,
                                      4'b1111, 4'b1110, 4'b1100, 4'b1000};

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // One cycle of stimulus plus its expected registered response.
    task automatic step(input logic rst, input logic v, input logic [3:0] code,
                        input logic clr, input logic [2:0] ph, input logic pv,
                        input logic lk, input logic tk, input logic ill,
                        input logic sq, input logic lkh, input logic sqh);
        exp_t e;
        @(negedge clk);
        reset = rst; in_valid = v; jc_in = code; err_clr = clr;
        if (rst) begin
            m_rc  = 8'd0;
            m_any = 1'b0;
        end else begin
            if (tk) m_rc = m_rc + 8'd1;
            m_any = (m_any & ~clr) | ill | sq;
        end
        e.ph = ph; e.pv = pv; e.lk = lk; e.tk = tk; e.rc = m_rc;
        e.ill = ill; e.sq = sq; e.any = m_any; e.lkh = lkh; e.sqh = sqh;
        exp_q.push_back(e);
    endtask

    // Correct successors while both instances are locked.
    task automatic run_locked(input int n);
        for (int i = 0; i < n; i++) begin
            int nph;
            nph = (cur_ph + 1) % 8;
            step(0, 1, JC[nph], 0, 3'(nph), 1, 1, (nph == 0), 0, 0, 1, 0);
            cur_ph = nph;
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("phase",       int'(phase),       int'(e.ph));
                chk("phase_valid", int'(phase_valid), int'(e.pv));
                chk("lock",        int'(lock),        int'(e.lk));
                chk("rev_tick",    int'(rev_tick),    int'(e.tk));
                chk("rev_count",   int'(rev_count),   int'(e.rc));
                chk("err_illegal", int'(err_illegal), int'(e.ill));
                chk("err_seq",     int'(err_seq),     int'(e.sq));
                chk("err_any",     int'(err_any),     int'(e.any));
                chk("hold_lock",   int'(lock_h),      int'(e.lkh));
                chk("hold_err_seq",int'(err_seq_h),   int'(e.sqh));
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : driver
        reset = 1'b1; in_valid = 1'b0; jc_in = 4'b0000; err_clr = 1'b0;
        m_rc = 8'd0; m_any = 1'b0; cur_ph = 0;

        // reset, two cycles
        step(1, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // illegal while acquiring, then clear sticky flag
        step(0, 1, 4'b0101, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 4'b0000, 1, 0, 0, 0, 0, 0, 0, 0, 0);

        // acquisition from 0000: lock after the 4th sample
        step(0, 1, JC[0], 0, 0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 1, JC[1], 0, 1, 1, 0, 0, 0, 0, 0, 0);
        step(0, 1, JC[2], 0, 2, 1, 0, 0, 0, 0, 0, 0);
        step(0, 1, JC[3], 0, 3, 1, 1, 0, 0, 0, 1, 0);
        cur_ph = 3;
        run_locked(4);
        // invalid sample with garbage code changes nothing
        step(0, 0, 4'b1010, 0, 7, 1, 1, 0, 0, 0, 1, 0);

        // wrap -> first revolution, then 256 more (count wraps back to 1)
        run_locked(1);
        run_locked(256 * 8);

        // illegal while locked, then relock from 0111
        run_locked(2);
        step(0, 1, 4'b0101, 0, 2, 0, 0, 0, 1, 0, 0, 0);
        step(0, 1, JC[3], 0, 3, 1, 0, 0, 0, 0, 0, 0);
        step(0, 1, JC[4], 0, 4, 1, 0, 0, 0, 0, 0, 0);
        step(0, 1, JC[5], 0, 5, 1, 0, 0, 0, 0, 0, 0);
        step(0, 1, JC[6], 0, 6, 1, 1, 0, 0, 0, 1, 0);
        cur_ph = 6;
        run_locked(2);
        step(0, 1, JC[1], 1, 1, 1, 1, 0, 0, 0, 1, 0);
        cur_ph = 1;
        run_locked(1);

        // locked at 0011, jump to 1110: sequence error, relock in 3 steps
        step(0, 1, JC[5], 0, 5, 1, 0, 0, 0, 1, 0, 1);
        step(0, 1, JC[6], 0, 6, 1, 0, 0, 0, 0, 0, 0);
        step(0, 1, JC[7], 0, 7, 1, 0, 0, 0, 0, 0, 0);
        step(0, 1, JC[0], 0, 0, 1, 1, 0, 0, 0, 1, 0);
        cur_ph = 0;
        run_locked(3);

        // repeated 0111: error without hold, ignored with hold
        step(0, 1, JC[3], 0, 3, 1, 0, 0, 0, 1, 1, 0);
        step(0, 1, JC[4], 0, 4, 1, 0, 0, 0, 0, 1, 0);
        step(0, 1, JC[5], 0, 5, 1, 0, 0, 0, 0, 1, 0);
        step(0, 1, JC[6], 0, 6, 1, 1, 0, 0, 0, 1, 0);

        // clear coincident with a new illegal: sticky flag stays set
        step(0, 1, 4'b1010, 1, 6, 0, 0, 0, 1, 0, 0, 0);
        step(0, 1, JC[7], 0, 7, 1, 0, 0, 0, 0, 0, 0);
        step(0, 1, JC[0], 0, 0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 1, JC[1], 0, 1, 1, 0, 0, 0, 0, 0, 0);
        step(0, 1, JC[2], 0, 2, 1, 1, 0, 0, 0, 1, 0);
        cur_ph = 2;
        run_locked(24);   // three more wraps: count reaches 5

        // reset while locked overrides a valid sample and a clear
        step(1, 1, JC[3], 1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
